// File: rtl/hazard_controller.sv
// Pipeline hazard controller: stall/flush/forward generation plus a memory-wait FSM with timeout.
// Define HAZ_PERF_CNT_EN to build the stall_cycles / flush_count performance counters.
module hazard_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_ERR} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic [WCNT_W-1:0] w_next_cnt;
    logic              r_mem_err;
    logic              w_next_err;
    logic              w_mem_stall;
    logic              w_lw_stall;

    assign w_mem_stall = MemReqM && !MemReadyM && (r_state != ST_ERR);
    assign w_lw_stall  = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_cnt;
            r_mem_err  <= w_next_err;
        end
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_wait_cnt;
        w_next_err   = r_mem_err;
        case (r_state)
            ST_RUN: begin
                if (w_mem_stall) begin
                    w_next_state = ST_MEM_WAIT;
                    w_next_cnt   = WCNT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (MemReadyM || !MemReqM) begin
                    w_next_state = ST_RUN;
                    w_next_cnt   = '0;
                end else if (r_wait_cnt == WCNT_LAST) begin
                    w_next_state = ST_ERR;
                    w_next_err   = 1'b1;
                end else begin
                    w_next_cnt = r_wait_cnt + WCNT_W'(1);
                end
            end
            ST_ERR:  ;
            default: w_next_state = ST_RUN;
        endcase
    end

    // A memory wait freezes E, so a taken branch there is simply re-presented once the wait ends.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!rst_n) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (r_state == ST_ERR) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else if (w_mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (w_lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (rst_n) begin
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
        end
    end

    assign mem_err = r_mem_err && rst_n;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (StallF)           r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            if (FlushD || FlushE) r_flush_count  <= r_flush_count + CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard controller for the 5-stage RISC-V core. It produces the hold and clear controls for the fetch PC and for the F/D, D/E, E/M and M/W pipeline registers. It also produces the E-stage forwarding selects. It sequences multi-cycle data-memory waits through a small state machine with a timeout watchdog. It sits beside the datapath and drives every stage register's `en`/`clr` pair (hold is active-high here; each register's `en` is tied to the matching `Stall*`).

## Interface
Parameters:
- `MEM_TIMEOUT`, 16: maximum consecutive memory-wait cycles before the error state (≥2).
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `Rs1D`, `Rs2D` in 5 each: source registers of the instruction in D.
- `Rs1E`, `Rs2E`, `RdE` in 5 each: source and destination registers of the instruction in E.
- `ResultSrcE0` in 1: the instruction in E is a load.
- `PCSrcE` in 1: branch taken or jump resolved in E.
- `RdM`, `RegWriteM` in 5, 1: destination register and write flag in M.
- `RdW`, `RegWriteW` in 5, 1: destination register and write flag in W.
- `MemReqM` in 1: the instruction in M accesses data memory.
- `MemReadyM` in 1: data memory completes the access this cycle.
- `StallF`, `StallD`, `StallE`, `StallM` out 1 each: hold the PC / stage register.
- `FlushD`, `FlushE`, `FlushW` out 1 each: clear the stage register to a bubble.
- `ForwardAE`, `ForwardBE` out 2 each: operand select, where 00 = register file, 10 = ALUResultM, 01 = ResultW.
- `mem_err` out 1: sticky memory-timeout error.
- `stall_cycles`, `flush_count` out `CNT_W` each: performance counters.

## Operation
- **States:**
  - RUN: normal operation.
  - MEM_WAIT: a memory access is outstanding.
  - ERR: memory timeout; terminal until reset.
- **Derived signals:**
  - `mem_stall` = `MemReqM` & !`MemReadyM` & (state ≠ ERR).
  - `lw_stall` = `ResultSrcE0` & (`RdE` ≠ 0) & (`RdE` == `Rs1D` | `RdE` == `Rs2D`).
- **Priority (highest first):**
  - ERR: all `Stall*` = 1; all `Flush*` = 0.
  - `mem_stall`:
    - `StallF`, `StallD`, `StallE`, `StallM` = 1 and `FlushW` = 1.
    - `FlushD` and `FlushE` = 0. A pending `PCSrcE` is therefore deferred: E is frozen, so it is re-presented when the wait ends.
  - `PCSrcE`: `FlushD` = 1, `FlushE` = 1, no stalls. This also suppresses `lw_stall`, because the instruction in D is wrong-path.
  - `lw_stall`: `StallF` = 1, `StallD` = 1, `FlushE` = 1.
  - Otherwise all `Stall*` and `Flush*` = 0.
- **Forwarding** (always combinational, independent of state), for operand A:
  - `ForwardAE` = 10 if `RegWriteM` & `RdM` ≠ 0 & `RdM` == `Rs1E`.
  - Else 01 if `RegWriteW` & `RdW` ≠ 0 & `RdW` == `Rs1E`.
  - Else 00.
  - M wins over W. `ForwardBE` is identical with `Rs2E`.
- **Transitions:**
  - RUN → MEM_WAIT when `mem_stall`; `wait_cnt` ← 1.
  - MEM_WAIT → RUN when `MemReadyM` or !`MemReqM`; `wait_cnt` ← 0.
  - MEM_WAIT → ERR when still `mem_stall` and `wait_cnt` == `MEM_TIMEOUT`-1; `mem_err` ← 1.
  - Otherwise in MEM_WAIT, `wait_cnt` ← `wait_cnt` + 1.
  - `wait_cnt` width is clog2(`MEM_TIMEOUT`+1).
- **Reset:**
  - While `rst_n` = 0: `FlushD`, `FlushE`, `FlushW` = 1, all `Stall*` = 0, `ForwardAE`/`ForwardBE` = 00, `mem_err` = 0.
  - On the first edge with `rst_n` low: state ← RUN, `wait_cnt` ← 0, counters ← 0.
  - Reset mid-wait or in ERR returns to RUN.

## Timing
- Stall, flush and forward outputs are combinational from the inputs and the current state; 0-cycle latency. The stage registers sample them at the next edge.
- A load-use stall lasts exactly 1 cycle. After the edge the load has moved to M and E holds a bubble, so `lw_stall` deasserts by itself.
- A memory wait of N cycles with `MemReadyM` low costs N stall cycles. A ready response in the first cycle of the request costs 0.
- `mem_err` rises on the edge that ends cycle `MEM_TIMEOUT` of a continuous wait and stays 1 until reset.
- Counters update on every non-reset edge. They wrap modulo 2^`CNT_W`.

## Configuration
- `HAZ_PERF_CNT_EN` defined:
  - `stall_cycles` increments on every cycle in which `StallF` = 1.
  - `flush_count` increments on every cycle in which `FlushD` or `FlushE` = 1, excluding reset.
- `HAZ_PERF_CNT_EN` undefined: both ports are driven constant 0 and the counter registers are not generated.

## Test plan
- Load `x5` in E (`ResultSrcE0` = 1, `RdE` = 5), D reads `Rs1D` = 5 → 1 cycle of `StallF` = `StallD` = `FlushE` = 1, then all 0. Repeat with `RdE` = 0 → no stall.
- `PCSrcE` = 1 together with a load-use match → `FlushD` = `FlushE` = 1 and `StallD` = 0.
- `MemReqM` = 1, `MemReadyM` low for 3 cycles then high → `StallF`..`StallM` and `FlushW` high for exactly 3 cycles; `PCSrcE` = 1 held throughout yields `FlushD` only on the 4th cycle. With the macro defined, `stall_cycles` = 3.
- `MEM_TIMEOUT` = 4, `MemReadyM` stuck low → `mem_err` = 1 after the 4th cycle and all stalls stuck at 1. `rst_n` low for 1 cycle → RUN and `mem_err` = 0.
- `Rs1E` = 7, `RdM` = `RdW` = 7, both `RegWrite*` = 1 → `ForwardAE` = 10. With `RegWriteM` = 0 → 01. With `Rs2E` = 0 → `ForwardBE` = 00.
